// File: rtl/difftest_step_pkg.sv
// Shared types and constants for the difftest step batcher.
package difftest_step_pkg;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StHalt = 1'b1
    } step_state_e;

    // simv_result value meaning "software has not reported a verdict yet".
    localparam logic [7:0] STEP_RESULT_NONE = 8'h0;

endpackage

// File: rtl/difftest_step_timer.sv
// Idle-batch timer: counts cycles a partial batch has waited, flags the last allowed cycle.
module difftest_step_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    // Wide enough to hold TIMEOUT-1 even when TIMEOUT is 1.
    localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);

    logic [CntWidth-1:0] count_q, count_d;

    // Clear wins over enable; the owner clears on every emission or empty accumulator.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CntWidth'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == CntWidth'(TIMEOUT - 1));

endmodule

// File: rtl/difftest_step_batcher.sv
// Batches checkable DUT cycles into one-cycle step counts; halts after the final flush.
module difftest_step_batcher
    import difftest_step_pkg::*;
#(
    parameter int unsigned STEP_WIDTH = 8,
    parameter int unsigned BATCH_SIZE = 64,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  flush_req,
    input  logic [7:0]            simv_result,
    output logic [STEP_WIDTH-1:0] step,
    output logic [STEP_WIDTH-1:0] pending,
    output logic                  halted
);

    step_state_e           state_q, state_d;
    logic [STEP_WIDTH-1:0] acc_q, acc_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic [STEP_WIDTH-1:0] acc_next;
    logic                  acc_next_nz;
    logic                  final_req;
    logic                  emit;
    logic                  timer_clr;
    logic                  timer_en;
    logic                  timer_tc;

    difftest_step_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk_i  (clock),
        .reset_i(reset),
        .clr_i  (timer_clr),
        .en_i   (timer_en),
        .tc_o   (timer_tc)
    );

    // Emission decision and next state; all triggers collapse into a single emission.
    always_comb begin
        acc_next    = acc_q + STEP_WIDTH'(in_valid);
        acc_next_nz = (acc_next != '0);
        final_req   = (simv_result != STEP_RESULT_NONE);
        emit        = 1'b0;
        state_d     = state_q;
        acc_d       = acc_q;
        step_d      = '0;
        timer_clr   = 1'b1;
        timer_en    = 1'b0;
        case (state_q)
            StRun: begin
                emit = (acc_next == STEP_WIDTH'(BATCH_SIZE))
                    || (timer_tc && acc_next_nz)
                    || (flush_req && acc_next_nz)
                    || final_req;
                if (emit) begin
                    // An empty final flush still emits, leaving step at 0.
                    step_d = acc_next;
                    acc_d  = '0;
                end else begin
                    acc_d     = acc_next;
                    timer_clr = !acc_next_nz;
                    timer_en  = acc_next_nz;
                end
                if (final_req) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                acc_d = '0;
            end
            default: begin
                state_d = StRun;
                acc_d   = '0;
            end
        endcase
    end

    // State, accumulator and step registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StRun;
            acc_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
        end
    end

    assign step    = step_q;
    assign pending = acc_q;
    assign halted  = (state_q == StHalt);

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Scoreboard bench for difftest_step_batcher with a cycle-level behavioural model.
module tb_difftest_step_batcher;

    localparam int unsigned SW = 8;
    localparam int unsigned BS = 4;
    localparam int unsigned TO = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          flush_req = 1'b0;
    logic [7:0]    simv_result = 8'h0;
    logic [SW-1:0] step;
    logic [SW-1:0] pending;
    logic          halted;

    always #5 clock = ~clock;

    difftest_step_batcher #(
        .STEP_WIDTH(SW),
        .BATCH_SIZE(BS),
        .TIMEOUT   (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .flush_req  (flush_req),
        .simv_result(simv_result),
        .step       (step),
        .pending    (pending),
        .halted     (halted)
    );

    typedef struct packed {
        logic [SW-1:0] step;
        logic [SW-1:0] pending;
        logic          halted;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    int            m_acc = 0;
    int            m_timer = 0;
    bit            m_halt = 1'b0;
    logic [SW-1:0] obs_step;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural model of one clock edge, straight from the operating rules.
    task automatic model_edge(input bit rst, input bit iv, input bit fr, input logic [7:0] sr,
                              output exp_t e);
        int  an;
        bit  fire;
        int  st;
        st = 0;
        if (rst) begin
            m_acc = 0; m_timer = 0; m_halt = 1'b0;
        end else if (m_halt) begin
            m_acc = 0;
        end else begin
            an   = m_acc + (iv ? 1 : 0);
            fire = (an == BS) || (m_timer == TO - 1 && an != 0) || (fr && an != 0) || (sr != 0);
            if (fire) begin
                st = an; m_acc = 0; m_timer = 0;
            end else begin
                m_acc   = an;
                m_timer = (an != 0) ? m_timer + 1 : 0;
            end
            if (sr != 0) m_halt = 1'b1;
        end
        e.step    = SW'(st);
        e.pending = SW'(m_acc);
        e.halted  = m_halt;
    endtask

    task automatic cycle(input bit rst, input bit iv, input bit fr, input logic [7:0] sr);
        exp_t e;
        exp_t p;
        reset = rst; in_valid = iv; flush_req = fr; simv_result = sr;
        model_edge(rst, iv, fr, sr, e);
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            p = sb.pop_front();
            check_eq("step", 32'(step), 32'(p.step));
            check_eq("pending", 32'(pending), 32'(p.pending));
            check_eq("halted", 32'(halted), 32'(p.halted));
        end
        obs_step = step;
    endtask

    initial begin
        int ek;
        int ev;
        int ne;

        // Reset state.
        cycle(1, 0, 0, 8'h0);
        cycle(1, 0, 0, 8'h0);
        check_eq("rst_step", 32'(step), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);

        // Full batch.
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'h0);
        check_eq("batch4", 32'(obs_step), 32'd4);
        cycle(0, 0, 0, 8'h0);
        check_eq("batch4_after", 32'(obs_step), 32'd0);
        check_eq("batch4_pending", 32'(pending), 32'd0);

        // Timeout emission of a partial batch.
        ek = -1; ev = 0; ne = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(0, k < 2, 0, 8'h0);
            if (obs_step != 0) begin
                ne++;
                if (ek < 0) begin ek = k; ev = int'(obs_step); end
            end
        end
        check_eq("timeout_cycle", 32'(ek), 32'd7);
        check_eq("timeout_val", 32'(ev), 32'd2);
        check_eq("timeout_count", 32'(ne), 32'd1);

        // Flush coinciding with batch-full: one emission only.
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h0);
        cycle(0, 1, 1, 8'h0);
        check_eq("flush_full", 32'(obs_step), 32'd4);
        ne = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(0, 0, 0, 8'h0);
            if (obs_step != 0) ne++;
        end
        check_eq("flush_full_once", 32'(ne), 32'd0);

        // Reset mid-batch discards the count.
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h0);
        cycle(1, 0, 0, 8'h0);
        check_eq("rst_mid_pending", 32'(pending), 32'd0);
        ne = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 0, 8'h0);
            if (obs_step != 0) ne++;
        end
        check_eq("rst_mid_no_emit", 32'(ne), 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'h0);
        check_eq("rst_mid_batch", 32'(obs_step), 32'd4);

        // Empty flush is suppressed.
        ne = 0;
        for (int k = 0; k < 50; k++) begin
            cycle(0, 0, k == 25, 8'h0);
            if (obs_step != 0) ne++;
        end
        check_eq("empty_flush", 32'(ne), 32'd0);

        // Random traffic without a verdict.
        for (int k = 0; k < 300; k++) begin
            cycle(0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, 8'h0);
        end

        // Final flush on verdict, then halt.
        cycle(0, 0, 1, 8'h0);
        cycle(0, 1, 0, 8'h0);
        cycle(0, 1, 0, 8'h0);
        cycle(0, 1, 0, 8'h01);
        check_eq("final_step", 32'(obs_step), 32'd3);
        check_eq("final_halted", 32'(halted), 32'd1);
        ne = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (k < 10) ? 8'h01 : 8'h00);
            if (obs_step != 0) ne++;
        end
        check_eq("halt_no_emit", 32'(ne), 32'd0);
        check_eq("halt_sticky", 32'(halted), 32'd1);

        // Reset leaves HALT; random traffic with occasional verdicts.
        cycle(1, 0, 0, 8'h0);
        check_eq("halt_reset", 32'(halted), 32'd0);
        for (int k = 0; k < 200; k++) begin
            if (k % 50 == 49) cycle(1, 0, 0, 8'h0);
            else cycle(0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
                       ($urandom_range(0, 39) == 0) ? 8'($urandom_range(1, 255)) : 8'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/difftest_step_batcher.md
# difftest_step_batcher

Synthesizable step generator sitting directly upstream of the deferred-result control stage. Counts DUT cycles that difftest must check, batches them, and presents a one-cycle `step` count that the downstream stage forwards to the software side via `simv_nstep`. Consumes `simv_result` fed back from that stage, performs a final flush, and then halts stepping once software reports a verdict.

## Interface
Parameters:
- STEP_WIDTH, 8: width of `step` and internal accumulator (matches CONFIG_DIFFTEST_STEPWIDTH).
- BATCH_SIZE, 64: accumulated count that forces an emission; legal range 1..2^STEP_WIDTH-1.
- TIMEOUT, 1024: cycles with a nonzero accumulator and no emission before a forced emission; must be ≥ 1.

Ports (reset is synchronous, active-high):
- clock  input  1  sampling clock, posedge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  one checkable DUT cycle occurred this clock.
- flush_req  input  1  emit the accumulated count now (e.g. end of test, trap).
- simv_result  input  8  verdict from the deferred-result stage; nonzero means software has finished.
- step  output  STEP_WIDTH  batch count; nonzero for exactly one cycle per emission, 0 otherwise.
- pending  output  STEP_WIDTH  current accumulator value (registered).
- halted  output  1  high once final flush done after a nonzero `simv_result`.

## Operation
- States: RUN, HALT (encoding in package).
- RUN: `acc_next = acc + in_valid`. Emit when any of:
  - `acc_next == BATCH_SIZE`;
  - `timer == TIMEOUT-1` and `acc_next != 0`;
  - `flush_req` and `acc_next != 0`;
  - `simv_result != 0` (final flush, emitted even if `acc_next == 0`, in which case `step` stays 0).
- On emit: `step <= acc_next`, `acc <= 0`, `timer <= 0`. Otherwise `step <= 0`, `acc <= acc_next`.
- Timer increments each cycle `acc_next != 0` and no emit; holds at 0 while accumulator empty.
- Multiple triggers in one cycle produce one emission of the full `acc_next`; never two.
- First cycle `simv_result != 0`: in_valid of that cycle is counted and included in the final emission; go HALT.
- HALT: in_valid, flush_req, and timer ignored; `step = 0`, `acc = 0`, `halted = 1` until reset. `simv_result` returning to 0 does not leave HALT.
- No overflow is possible: `acc` never exceeds BATCH_SIZE.

## Timing
- Reset values: `step = 0`, `pending = 0`, `halted = 0`, state RUN, timer 0.
- Latency: trigger sampled at posedge N, `step` valid for cycle N+1 only (downstream samples on negedge within that cycle).
- `halted` rises in the same cycle as the final `step` is presented.
- Reset asserted mid-batch discards the accumulator; no emission for discarded counts.
- Back-to-back emissions are legal (BATCH_SIZE=1 with continuous in_valid gives `step = 1` every cycle).

## Structure
- Package `difftest_step_pkg`: state enum (RUN, HALT), and a `STEP_RESULT_NONE = 8'h0` constant.
- One natural sub-module: `difftest_step_timer` (TIMEOUT counter with clear/enable, terminal-count output). Everything else stays in the top.

## Test plan
Bench parameters: STEP_WIDTH=8, BATCH_SIZE=4, TIMEOUT=8.
- in_valid high for 4 cycles from reset release -> `step = 4` for exactly one cycle after the 4th; `pending` returns to 0.
- in_valid high 2 cycles then low -> `step = 2` once, 8 cycles after the accumulator first became nonzero; never earlier.
- in_valid high 3 cycles, flush_req together with 4th in_valid -> single `step = 4`, no second emission.
- 2 counted cycles, then `simv_result = 8'h01` with in_valid=1 -> `step = 3` and `halted = 1` next cycle; further in_valid/flush_req give `step = 0` forever; `simv_result` back to 0 keeps `halted = 1`.
- 3 counted cycles, reset pulse -> no emission, `pending = 0`; next 4 in_valid yield `step = 4`.
- Idle 50 cycles with in_valid=0, flush_req pulsed -> `step` stays 0 (empty flush suppressed).
